// File: rtl/rv32_pkg.sv
// Shared RV32 front-end definitions: fetch FSM states and common encodings.
package rv32_pkg;

    typedef enum logic [1:0] {
        FETCH_REQ   = 2'd0,
        FETCH_WAIT  = 2'd1,
        FETCH_HOLD  = 2'd2,
        FETCH_DRAIN = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam logic [31:0] INSTR_STEP = 32'd4;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_hold_reg.sv
// One-entry valid/ready holding register presenting a fetched pc/instr pair to IF/ID.
module fetch_hold_reg
    import rv32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        clear_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o
);

    logic        valid_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;

    // A squash leaves a NOP behind so a stale word never looks like real data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= 32'h0;
            instr_q <= 32'h0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
        end else if (load_i) begin
            valid_q <= 1'b1;
            pc_q    <= pc_i;
            instr_q <= instr_i;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request, redirect/trap squash, hold for IF/ID.
module pc_fetch_ctrl
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_PC  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        trap,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        if_ready,
    output logic        flush,
    output logic        misalign
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic         flush_q, flush_d;
    logic         misalign_q, misalign_d;
    logic         kill;
    logic         bad_redirect;
    logic [31:0]  kill_pc;
    logic         granted;
    logic         load;

    always_comb begin
        bad_redirect = redirect_valid && !trap && is_misaligned(redirect_pc);
        kill         = trap || redirect_valid;
        kill_pc      = (trap || bad_redirect) ? TRAP_PC : redirect_pc;
    end

    // HOLD may launch the next fetch in the same cycle IF/ID takes the current one.
    always_comb begin
        imem_req = rst_n && !stall &&
                   ((state_q == FETCH_REQ) || ((state_q == FETCH_HOLD) && if_ready));
        granted  = imem_req && imem_gnt;
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fetch_pc_d = fetch_pc_q;
        load       = 1'b0;
        flush_d    = kill;
        misalign_d = bad_redirect;

        if (granted) begin
            fetch_pc_d = pc_q;
        end

        case (state_q)
            FETCH_REQ: begin
                if (granted) begin
                    state_d = kill ? FETCH_DRAIN : FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (imem_rvalid) begin
                    state_d = kill ? FETCH_REQ : FETCH_HOLD;
                    load    = !kill;
                end else if (kill) begin
                    state_d = FETCH_DRAIN;
                end
            end
            FETCH_HOLD: begin
                if (granted) begin
                    state_d = kill ? FETCH_DRAIN : FETCH_WAIT;
                end else if (if_ready || kill) begin
                    state_d = FETCH_REQ;
                end
            end
            FETCH_DRAIN: begin
                if (imem_rvalid) begin
                    state_d = FETCH_REQ;
                end
            end
            default: state_d = FETCH_REQ;
        endcase

        if (kill) begin
            pc_d = kill_pc;
        end else if (granted) begin
            pc_d = pc_q + INSTR_STEP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH_REQ;
            pc_q       <= RESET_PC;
            fetch_pc_q <= RESET_PC;
            flush_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fetch_pc_q <= fetch_pc_d;
            flush_q    <= flush_d;
            misalign_q <= misalign_d;
        end
    end

    fetch_hold_reg u_hold (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load),
        .clear_i (kill),
        .pc_i    (fetch_pc_q),
        .instr_i (imem_rdata),
        .ready_i (if_ready),
        .valid_o (if_valid),
        .pc_o    (if_pc),
        .instr_o (if_instr)
    );

    assign imem_addr = pc_q;
    assign flush     = flush_q;
    assign misalign  = misalign_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed per-cycle vector bench for pc_fetch_ctrl with hand-computed expectations.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] TRAP = 32'h0000_0200;
    localparam int          NVEC = 28;

    logic        clk = 1'b0;
    logic        rstN;
    logic        stall, redirValid, trap, gnt, rvalid, ifReady;
    logic [31:0] redirPc, rdata;
    logic        imemReq, ifValid, flush, misalign;
    logic [31:0] imemAddr, ifPc, ifInstr;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        st, rv;
        logic [31:0] rpc;
        logic        tr, g, rvl;
        logic [31:0] rd;
        logic        rdy;
        logic        eReq;
        logic [31:0] eAddr;
        logic        eValid;
        logic [31:0] ePc, eInstr;
        logic        eFlush, eMis;
    } vec_t;

    vec_t vecs [NVEC];

    pc_fetch_ctrl #(.RESET_PC(32'h0), .TRAP_PC(TRAP)) dut (
        .clk            (clk),
        .rst_n          (rstN),
        .stall          (stall),
        .redirect_valid (redirValid),
        .redirect_pc    (redirPc),
        .trap           (trap),
        .imem_req       (imemReq),
        .imem_addr      (imemAddr),
        .imem_gnt       (gnt),
        .imem_rvalid    (rvalid),
        .imem_rdata     (rdata),
        .if_valid       (ifValid),
        .if_pc          (ifPc),
        .if_instr       (ifInstr),
        .if_ready       (ifReady),
        .flush          (flush),
        .misalign       (misalign)
    );

    always #5 clk = ~clk;

    function automatic vec_t mkVec(input logic st, rv, input logic [31:0] rpc,
                                   input logic tr, g, rvl, input logic [31:0] rd,
                                   input logic rdy, eReq, input logic [31:0] eAddr,
                                   input logic eValid, input logic [31:0] ePc, eInstr,
                                   input logic eFlush, eMis);
        vec_t v;
        v.st = st; v.rv = rv; v.rpc = rpc; v.tr = tr; v.g = g; v.rvl = rvl;
        v.rd = rd; v.rdy = rdy; v.eReq = eReq; v.eAddr = eAddr; v.eValid = eValid;
        v.ePc = ePc; v.eInstr = eInstr; v.eFlush = eFlush; v.eMis = eMis;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        stall = v.st; redirValid = v.rv; redirPc = v.rpc; trap = v.tr;
        gnt = v.g; rvalid = v.rvl; rdata = v.rd; ifReady = v.rdy;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input vec_t v);
        checkOutput({tag, " imem_req"}, {31'b0, imemReq},  {31'b0, v.eReq});
        checkOutput({tag, " imem_addr"}, imemAddr,          v.eAddr);
        checkOutput({tag, " if_valid"}, {31'b0, ifValid},  {31'b0, v.eValid});
        checkOutput({tag, " if_pc"},     ifPc,              v.ePc);
        checkOutput({tag, " if_instr"},  ifInstr,           v.eInstr);
        checkOutput({tag, " flush"},    {31'b0, flush},    {31'b0, v.eFlush});
        checkOutput({tag, " misalign"}, {31'b0, misalign}, {31'b0, v.eMis});
    endtask

    initial begin
        vec_t idle;
        // Columns: stall redir rpc trap gnt rvalid rdata rdy | req addr valid pc instr flush misalign
        vecs[0]  = mkVec(0,0,0,0, 1,0,0,0,                      1,32'h0,       0,32'h0,       32'h0,        0,0);
        vecs[1]  = mkVec(0,0,0,0, 1,1,32'h1111_0000,0,          0,32'h4,       0,32'h0,       32'h0,        0,0);
        vecs[2]  = mkVec(0,0,0,0, 1,0,0,1,                      1,32'h4,       1,32'h0,       32'h1111_0000,0,0);
        vecs[3]  = mkVec(0,0,0,0, 1,1,32'h2222_0004,0,          0,32'h8,       0,32'h0,       32'h1111_0000,0,0);
        vecs[4]  = mkVec(0,0,0,0, 1,0,0,1,                      1,32'h8,       1,32'h4,       32'h2222_0004,0,0);
        vecs[5]  = mkVec(0,0,0,0, 0,1,32'h3333_0008,0,          0,32'hC,       0,32'h4,       32'h2222_0004,0,0);
        vecs[6]  = mkVec(0,0,0,0, 1,0,0,0,                      0,32'hC,       1,32'h8,       32'h3333_0008,0,0);
        vecs[7]  = mkVec(0,0,0,0, 1,0,0,0,                      0,32'hC,       1,32'h8,       32'h3333_0008,0,0);
        vecs[8]  = mkVec(1,0,0,0, 1,0,0,0,                      0,32'hC,       1,32'h8,       32'h3333_0008,0,0);
        vecs[9]  = mkVec(1,0,0,0, 1,0,0,1,                      0,32'hC,       1,32'h8,       32'h3333_0008,0,0);
        vecs[10] = mkVec(1,0,0,0, 1,0,0,0,                      0,32'hC,       0,32'h8,       32'h3333_0008,0,0);
        vecs[11] = mkVec(0,0,0,0, 1,0,0,0,                      1,32'hC,       0,32'h8,       32'h3333_0008,0,0);
        vecs[12] = mkVec(0,1,32'h100,0, 0,0,0,0,                0,32'h10,      0,32'h8,       32'h3333_0008,0,0);
        vecs[13] = mkVec(0,0,0,0, 0,1,32'hDEAD_BEEF,0,          0,32'h100,     0,32'h8,       32'h13,       1,0);
        vecs[14] = mkVec(0,0,0,0, 1,0,0,0,                      1,32'h100,     0,32'h8,       32'h13,       0,0);
        vecs[15] = mkVec(0,0,0,0, 0,1,32'h4444_0100,0,          0,32'h104,     0,32'h8,       32'h13,       0,0);
        vecs[16] = mkVec(0,1,32'h300,1, 0,0,0,0,                0,32'h104,     1,32'h100,     32'h4444_0100,0,0);
        vecs[17] = mkVec(0,0,0,0, 0,0,0,0,                      1,TRAP,        0,32'h100,     32'h13,       1,0);
        vecs[18] = mkVec(0,1,32'hFFFF_FFFC,0, 1,0,0,0,          1,TRAP,        0,32'h100,     32'h13,       0,0);
        vecs[19] = mkVec(0,0,0,0, 0,0,0,0,                      0,32'hFFFF_FFFC,0,32'h100,    32'h13,       1,0);
        vecs[20] = mkVec(0,0,0,0, 0,1,32'hBAD0_0200,0,          0,32'hFFFF_FFFC,0,32'h100,    32'h13,       0,0);
        vecs[21] = mkVec(0,0,0,0, 1,0,0,0,                      1,32'hFFFF_FFFC,0,32'h100,    32'h13,       0,0);
        vecs[22] = mkVec(0,0,0,0, 0,1,32'h5555_FFFC,0,          0,32'h0,       0,32'h100,     32'h13,       0,0);
        vecs[23] = mkVec(0,1,32'h102,0, 0,0,0,0,                0,32'h0,       1,32'hFFFF_FFFC,32'h5555_FFFC,0,0);
        vecs[24] = mkVec(0,0,0,0, 0,0,0,0,                      1,TRAP,        0,32'hFFFF_FFFC,32'h13,      1,1);
        vecs[25] = mkVec(0,0,0,0, 1,0,0,0,                      1,TRAP,        0,32'hFFFF_FFFC,32'h13,      0,0);
        vecs[26] = mkVec(0,1,32'h40,0, 0,1,32'h6666_0200,0,     0,32'h204,     0,32'hFFFF_FFFC,32'h13,      0,0);
        vecs[27] = mkVec(0,0,0,0, 0,0,0,0,                      1,32'h40,      0,32'hFFFF_FFFC,32'h13,      1,0);

        idle = mkVec(0,0,0,0, 0,0,0,0, 0,32'h0, 0,32'h0,32'h0, 0,0);
        applyStimulus(idle);
        rstN = 1'b0;
        repeat (2) @(negedge clk);
        #1 checkAll("reset", idle);

        rstN = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1 checkAll($sformatf("row%0d", i), vecs[i]);
        end

        // Reset while a request is outstanding, then a stray rvalid after release.
        @(negedge clk);
        applyStimulus(mkVec(0,0,0,0, 1,0,0,0, 0,0,0,0,0,0,0));
        #1 checkOutput("mid req", {31'b0, imemReq}, 32'd1);
        @(negedge clk);
        applyStimulus(idle);
        rstN = 1'b0;
        #1 checkAll("mid reset", idle);
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus(mkVec(1,0,0,0, 0,1,32'h7777_7777,0, 0,0,0,0,0,0,0));
        #1 checkOutput("stray req", {31'b0, imemReq}, 32'd0);
        @(negedge clk);
        applyStimulus(idle);
        #1 checkAll("stray rvalid", mkVec(0,0,0,0, 0,0,0,0, 1,32'h0, 0,32'h0,32'h0, 0,0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter TRAP_PC, default 32'h0000_0000, the redirect target on trap or misaligned redirect.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, reset, asynchronous assert, active-low.
REQ-005 SHALL have port stall, input, 1 bit, hazard stall from decode; freezes issue of new fetches.
REQ-006 SHALL have port redirect_valid, input, 1 bit, taken branch/jump resolved in EX (PCsrc).
REQ-007 SHALL have port redirect_pc, input, 32 bits, branch/jump target (PC_next).
REQ-008 SHALL have port trap, input, 1 bit, invalid-instruction indication.
REQ-009 SHALL have port imem_req, output, 1 bit, instruction-memory request.
REQ-010 SHALL have port imem_addr, output, 32 bits, request address.
REQ-011 SHALL have port imem_gnt, input, 1 bit, request accepted this cycle.
REQ-012 SHALL have port imem_rvalid, input, 1 bit, read data valid.
REQ-013 SHALL have port imem_rdata, input, 32 bits, read data.
REQ-014 SHALL have port if_valid, output, 1 bit, fetched instruction available to IF/ID.
REQ-015 SHALL have port if_pc, output, 32 bits, PC of the presented instruction.
REQ-016 SHALL have port if_instr, output, 32 bits, the presented instruction word.
REQ-017 SHALL have port if_ready, input, 1 bit, IF/ID accepts the presented instruction.
REQ-018 SHALL have port flush, output, 1 bit, one-cycle pulse to squash IF/ID and ID/EX.
REQ-019 SHALL have port misalign, output, 1 bit, one-cycle pulse when redirect_pc[1:0] != 0.

Function
REQ-020 SHALL implement states REQ, WAIT, HOLD, DRAIN, with REQ entered on reset release.
REQ-021 In REQ, SHALL assert imem_req with imem_addr = pc_q while stall=0; on imem_gnt go to WAIT and set pc_q = pc_q + 4, wrapping modulo 2^32.
REQ-022 SHALL allow at most one outstanding request.
REQ-023 In WAIT, on imem_rvalid SHALL capture imem_rdata and its address, assert if_valid, and go to HOLD.
REQ-024 In HOLD, SHALL keep if_valid, if_pc, and if_instr stable until if_ready; on if_ready go to REQ, or issue the next request in the same cycle if stall=0.
REQ-025 Priority SHALL be trap > redirect_valid > stall > normal sequencing.
REQ-026 On trap, SHALL set pc_q = TRAP_PC, pulse flush, and drop if_valid next cycle.
REQ-027 On redirect_valid, SHALL set pc_q = redirect_pc, pulse flush, and drop if_valid next cycle.
REQ-028 On redirect_valid with redirect_pc[1:0] != 0, SHALL pulse misalign and behave as trap.
REQ-029 A redirect or trap during WAIT SHALL go to DRAIN; DRAIN discards the pending rvalid data and then goes to REQ with the new pc_q.
REQ-030 A redirect coinciding with imem_rvalid in WAIT SHALL discard that data and go directly to REQ.
REQ-031 A redirect coinciding with imem_gnt in REQ SHALL go to DRAIN, so the granted stale fetch is discarded.
REQ-032 Latency: grant to if_valid SHALL be rvalid latency + 1 cycle; redirect to the new-target imem_req SHALL be 1 cycle when no request is outstanding.
REQ-033 stall SHALL never drop an asserted if_valid or an outstanding request.

Reset
REQ-034 While rst_n=0, SHALL hold pc_q=RESET_PC, state=REQ, and imem_req, if_valid, flush, misalign=0 with if_pc and if_instr at 0.
REQ-035 Reset asserted mid-transaction SHALL abandon the outstanding request; an rvalid arriving after reset release with no outstanding request SHALL be ignored.

Structure
REQ-036 SHALL take the fetch_state_e enum and the NOP encoding 32'h0000_0013 from shared package rv32_pkg.
REQ-037 SHALL contain one sub-module, fetch_hold_reg, a 1-entry valid/ready holding register for pc and instr.

Verification
REQ-038 Reset release with gnt=1 and rvalid 1 cycle later: imem_addr SHALL be 0x0, 0x4, 0x8, and if_pc SHALL follow in order.
REQ-039 if_ready=0 for 3 cycles while presenting pc 0x8: if_pc and if_instr SHALL stay stable and no new imem_req is issued.
REQ-040 redirect_valid with redirect_pc=0x100 during WAIT: flush SHALL pulse, the stale rvalid is dropped, and the next imem_addr is 0x100.
REQ-041 trap with redirect_valid in the same cycle: pc SHALL become TRAP_PC and flush pulses once.
REQ-042 redirect_pc=0x102: misalign SHALL pulse and the next imem_addr is TRAP_PC.
REQ-043 pc_q=0xFFFF_FFFC fetched: the next imem_addr SHALL be 0x0000_0000.
